// File: rtl/decode_alu_mem_pkg.sv
// decode_alu_mem_pkg
// Shared definitions for the execute slice: opcode and funct encodings of the
// supported MIPS subset, and the 4-bit ALU operation enum.
// No ports (package).
package decode_alu_mem_pkg;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instruction[5:0]
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8
    } alu_op_t;

endpackage

// File: rtl/decode_alu_mem_alu.sv
// decode_alu_mem_alu
// Combinational 32-bit ALU with zero flag.
// Ports:
//   op     : ALU operation (alu_op_t)
//   a, b   : operands; for shifts, a is the value being shifted
//   shamt  : shift amount for SLL/SRL
//   result : 32-bit wrap-around result
//   zero   : result == 0
module decode_alu_mem_alu
    import decode_alu_mem_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = a + b;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            default: result = a + b;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/decode_alu_mem_data_memory.sv
// decode_alu_mem_data_memory
// Word-addressed data memory: synchronous write, combinational read,
// asynchronous clear of every word while reset is asserted.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   we         : write enable, sampled on the rising clock edge
//   addr       : word index
//   wdata      : word to store
//   rdata      : word currently stored at addr
module decode_alu_mem_data_memory #(
    parameter int MEM_DEPTH = 64,
    parameter int MEM_AW    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [MEM_DEPTH];

    // Reset wipes the whole array, so reads during reset naturally return 0
    // and writes cannot land until reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/decode_alu_mem.sv
// decode_alu_mem
// Single-cycle execute slice: instruction decode, ALU and data memory.
// Ports:
//   clk, rst_n            : clock (memory writes) and async active-low reset
//   instruction           : current instruction word
//   rs_data, rt_data      : register-file read data
//   opcode..imm, adr      : raw instruction fields
//   dest_reg              : write-back register (rt for immediates, else rd)
//   regwrite, memwrite,
//   memread, imm_reg, jump: decoded controls
//   alu_op                : ALU operation code
//   alu_result, zero      : ALU output and zero flag (result is also the address)
//   branch_taken          : beq/bne outcome
//   mem_read_data         : memory word at the addressed location
//   write_data            : write-back value (load data or ALU result)
module decode_alu_mem
    import decode_alu_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int MEM_AW    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [5:0]  opcode,
    output logic [25:0] adr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [4:0]  dest_reg,
    output logic        regwrite,
    output logic        memwrite,
    output logic        memread,
    output logic [3:0]  alu_op,
    output logic        imm_reg,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        branch_taken,
    output logic        jump,
    output logic [31:0] mem_read_data,
    output logic [31:0] write_data
);

    alu_op_t     alu_sel;
    logic        sign_ext;
    logic        is_beq;
    logic        is_bne;
    logic [31:0] ext_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;

    assign opcode = instruction[31:26];
    assign adr    = instruction[25:0];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign shamt  = instruction[10:6];
    assign funct  = instruction[5:0];
    assign imm    = instruction[15:0];

    // Decoder: everything defaults to a harmless ADD with no side effects,
    // so unknown opcodes and unknown R-type functs never write anything.
    always_comb begin
        alu_sel  = ALU_ADD;
        regwrite = 1'b0;
        memwrite = 1'b0;
        memread  = 1'b0;
        imm_reg  = 1'b0;
        jump     = 1'b0;
        sign_ext = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                regwrite = 1'b1;
                case (funct)
                    FN_ADD:  alu_sel = ALU_ADD;
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_XOR:  alu_sel = ALU_XOR;
                    FN_NOR:  alu_sel = ALU_NOR;
                    FN_SLT:  alu_sel = ALU_SLT;
                    FN_SLL:  alu_sel = ALU_SLL;
                    FN_SRL:  alu_sel = ALU_SRL;
                    default: regwrite = 1'b0;
                endcase
            end
            OP_ADDI: begin
                regwrite = 1'b1; imm_reg = 1'b1; sign_ext = 1'b1;
            end
            OP_SLTI: begin
                alu_sel = ALU_SLT; regwrite = 1'b1; imm_reg = 1'b1; sign_ext = 1'b1;
            end
            OP_ANDI: begin
                alu_sel = ALU_AND; regwrite = 1'b1; imm_reg = 1'b1;
            end
            OP_ORI: begin
                alu_sel = ALU_OR; regwrite = 1'b1; imm_reg = 1'b1;
            end
            OP_LW: begin
                regwrite = 1'b1; memread = 1'b1; imm_reg = 1'b1; sign_ext = 1'b1;
            end
            OP_SW: begin
                memwrite = 1'b1; imm_reg = 1'b1; sign_ext = 1'b1;
            end
            OP_BEQ: begin
                alu_sel = ALU_SUB; is_beq = 1'b1;
            end
            OP_BNE: begin
                alu_sel = ALU_SUB; is_bne = 1'b1;
            end
            OP_J:    jump = 1'b1;
            default: alu_sel = ALU_ADD;
        endcase
    end

    assign alu_op   = alu_sel;
    assign dest_reg = imm_reg ? rt : rd;
    assign ext_imm  = sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};

    // Shifts operate on rt with the amount taken from shamt, not from B.
    assign alu_a = (alu_sel == ALU_SLL || alu_sel == ALU_SRL) ? rt_data : rs_data;
    assign alu_b = imm_reg ? ext_imm : rt_data;

    decode_alu_mem_alu u_alu (
        .op     (alu_sel),
        .a      (alu_a),
        .b      (alu_b),
        .shamt  (shamt),
        .result (alu_result),
        .zero   (zero)
    );

    assign branch_taken = (is_beq & zero) | (is_bne & ~zero);

    // Byte offset bits and bits above the array size are dropped, so
    // addresses wrap around the memory.
    decode_alu_mem_data_memory #(
        .MEM_DEPTH (MEM_DEPTH),
        .MEM_AW    (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (memwrite),
        .addr  (alu_result[MEM_AW+1:2]),
        .wdata (rt_data),
        .rdata (mem_read_data)
    );

    assign write_data = memread ? mem_read_data : alu_result;

endmodule

// File: tb/tb_decode_alu_mem.sv
// tb_decode_alu_mem
// Self-checking bench for decode_alu_mem: directed scenarios plus random
// instructions compared against an instruction-level reference model.
module tb_decode_alu_mem;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [5:0]  opcode;
    logic [25:0] adr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [4:0]  dest_reg;
    logic        regwrite;
    logic        memwrite;
    logic        memread;
    logic [3:0]  alu_op;
    logic        imm_reg;
    logic [31:0] alu_result;
    logic        zero;
    logic        branch_taken;
    logic        jump;
    logic [31:0] mem_read_data;
    logic [31:0] write_data;

    int checks = 0;
    int errors = 0;

    // Reference memory contents, one word per index
    logic [31:0] model_mem [64];

    typedef struct {
        logic [3:0]  aop;
        logic        rw;
        logic        mw;
        logic        mr;
        logic        ir;
        logic        jp;
        logic        beq;
        logic        bne;
        logic [31:0] res;
    } exp_t;

    decode_alu_mem dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instruction   (instruction),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .opcode        (opcode),
        .adr           (adr),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .shamt         (shamt),
        .funct         (funct),
        .imm           (imm),
        .dest_reg      (dest_reg),
        .regwrite      (regwrite),
        .memwrite      (memwrite),
        .memread       (memread),
        .alu_op        (alu_op),
        .imm_reg       (imm_reg),
        .alu_result    (alu_result),
        .zero          (zero),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .mem_read_data (mem_read_data),
        .write_data    (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkR(input int s, input int t, input int d, input int sh, input int fn);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] mkI(input int op, input int s, input int t, input int im);
        return {6'(op), 5'(s), 5'(t), 16'(im)};
    endfunction

    // Instruction semantics: what each instruction does to the machine,
    // expressed directly with arithmetic on the register values.
    function automatic exp_t computeModel(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int unsigned sx;
        int unsigned zx;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0000, ins[15:0]};
        e = '{aop: 4'd0, rw: 1'b0, mw: 1'b0, mr: 1'b0, ir: 1'b0, jp: 1'b0,
              beq: 1'b0, bne: 1'b0, res: a + b};
        case (ins[31:26])
            6'h00: begin
                e.rw = 1'b1;
                case (ins[5:0])
                    6'h20: begin e.aop = 0; e.res = a + b; end
                    6'h22: begin e.aop = 1; e.res = a - b; end
                    6'h24: begin e.aop = 2; e.res = a & b; end
                    6'h25: begin e.aop = 3; e.res = a | b; end
                    6'h26: begin e.aop = 4; e.res = a ^ b; end
                    6'h27: begin e.aop = 5; e.res = ~(a | b); end
                    6'h2A: begin e.aop = 6; e.res = (int'(a) < int'(b)) ? 1 : 0; end
                    6'h00: begin e.aop = 7; e.res = b << ins[10:6]; end
                    6'h02: begin e.aop = 8; e.res = b >> ins[10:6]; end
                    default: e.rw = 1'b0;
                endcase
            end
            6'h08: begin e.rw = 1; e.ir = 1; e.res = a + sx; end
            6'h0A: begin e.rw = 1; e.ir = 1; e.aop = 6; e.res = (int'(a) < int'(sx)) ? 1 : 0; end
            6'h0C: begin e.rw = 1; e.ir = 1; e.aop = 2; e.res = a & zx; end
            6'h0D: begin e.rw = 1; e.ir = 1; e.aop = 3; e.res = a | zx; end
            6'h23: begin e.rw = 1; e.ir = 1; e.mr = 1; e.res = a + sx; end
            6'h2B: begin e.mw = 1; e.ir = 1; e.res = a + sx; end
            6'h04: begin e.aop = 1; e.beq = 1; e.res = a - b; end
            6'h05: begin e.aop = 1; e.bne = 1; e.res = a - b; end
            6'h02: e.jp = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic checkOne(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, obs, expv);
        end
    endtask

    // Compare every output against the reference model for the current inputs
    task automatic checkOutput(input string tag);
        exp_t e;
        logic [31:0] md;
        e  = computeModel(instruction, rs_data, rt_data);
        md = rst_n ? model_mem[e.res[7:2]] : 32'h0;
        checkOne({tag, ".opcode"},   32'(opcode),   32'(instruction[31:26]));
        checkOne({tag, ".adr"},      32'(adr),      32'(instruction[25:0]));
        checkOne({tag, ".rs"},       32'(rs),       32'(instruction[25:21]));
        checkOne({tag, ".rt"},       32'(rt),       32'(instruction[20:16]));
        checkOne({tag, ".rd"},       32'(rd),       32'(instruction[15:11]));
        checkOne({tag, ".shamt"},    32'(shamt),    32'(instruction[10:6]));
        checkOne({tag, ".funct"},    32'(funct),    32'(instruction[5:0]));
        checkOne({tag, ".imm"},      32'(imm),      32'(instruction[15:0]));
        checkOne({tag, ".dest_reg"}, 32'(dest_reg), e.ir ? 32'(instruction[20:16]) : 32'(instruction[15:11]));
        checkOne({tag, ".regwrite"}, 32'(regwrite), 32'(e.rw));
        checkOne({tag, ".memwrite"}, 32'(memwrite), 32'(e.mw));
        checkOne({tag, ".memread"},  32'(memread),  32'(e.mr));
        checkOne({tag, ".imm_reg"},  32'(imm_reg),  32'(e.ir));
        checkOne({tag, ".jump"},     32'(jump),     32'(e.jp));
        checkOne({tag, ".alu_op"},   32'(alu_op),   32'(e.aop));
        checkOne({tag, ".alu_result"}, alu_result,  e.res);
        checkOne({tag, ".zero"},     32'(zero),     32'(e.res == 0));
        checkOne({tag, ".branch"},   32'(branch_taken), 32'((e.beq && e.res == 0) || (e.bne && e.res != 0)));
        checkOne({tag, ".mem_read_data"}, mem_read_data, md);
        checkOne({tag, ".write_data"}, write_data,  e.mr ? md : e.res);
    endtask

    // Drive inputs away from the rising edge and let them settle
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        instruction = ins;
        rs_data     = a;
        rt_data     = b;
        #1;
    endtask

    // One rising edge; the model stores on the edge if the instruction is a store
    task automatic tickClock();
        exp_t e;
        @(posedge clk);
        e = computeModel(instruction, rs_data, rt_data);
        if (e.mw && rst_n) model_mem[e.res[7:2]] = rt_data;
        @(negedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    endtask

    initial begin
        logic [5:0]  op_pool [14];
        logic [5:0]  fn_pool [10];
        logic [31:0] ins;
        logic [31:0] a;
        op_pool = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A,
                    6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F, 6'h11};
        fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h3F};

        rst_n       = 1'b1;
        instruction = 32'h0;
        rs_data     = 32'h0;
        rt_data     = 32'h0;
        clearModel();
        #2;
        rst_n = 1'b0;
        @(negedge clk);

        // Reset: memory reads zero, store attempts are blocked
        applyStimulus(mkI(6'h2B, 0, 0, 0), 32'h0, 32'hFFFF_FFFF);
        checkOne("reset.mem0", mem_read_data, 32'h0);
        tickClock();
        checkOne("reset.blocked", mem_read_data, 32'h0);
        checkOutput("reset");
        rst_n = 1'b1;
        #1;

        // R-type decode of the documented pattern
        applyStimulus(32'h000A_5B22, 32'h0, 32'h0);
        checkOne("dec.rt", 32'(rt), 32'd10);
        checkOne("dec.rd", 32'(rd), 32'd11);
        checkOne("dec.shamt", 32'(shamt), 32'd12);
        checkOne("dec.imm", 32'(imm), 32'h5B22);
        checkOne("dec.adr", 32'(adr), 32'h00A5B22);
        checkOne("dec.alu_op", 32'(alu_op), 32'd1);
        checkOne("dec.dest_reg", 32'(dest_reg), 32'd11);
        checkOutput("dec");

        // ALU corner cases
        applyStimulus(mkI(6'h08, 1, 2, 16'hFFFF), 32'd5, 32'h0);
        checkOne("addi.result", alu_result, 32'd4);
        checkOutput("addi");
        applyStimulus(mkR(1, 2, 3, 0, 6'h22), 32'd3, 32'd3);
        checkOne("sub.zero", 32'(zero), 32'd1);
        checkOutput("sub");
        applyStimulus(mkR(1, 2, 3, 0, 6'h2A), 32'hFFFF_FFFF, 32'd1);
        checkOne("slt.result", alu_result, 32'd1);
        checkOutput("slt");
        applyStimulus(mkR(0, 1, 2, 31, 6'h02), 32'h0, 32'h8000_0000);
        checkOne("srl.result", alu_result, 32'd1);
        checkOutput("srl");

        // Store then load at the same address
        applyStimulus(mkI(6'h2B, 1, 2, 4), 32'h10, 32'hDEAD_BEEF);
        checkOutput("sw");
        tickClock();
        applyStimulus(mkI(6'h23, 1, 3, 4), 32'h10, 32'h0);
        checkOne("lw.data", mem_read_data, 32'hDEAD_BEEF);
        checkOne("lw.write_data", write_data, 32'hDEAD_BEEF);
        checkOne("lw.dest_reg", 32'(dest_reg), 32'd3);
        checkOutput("lw");

        // Branches
        applyStimulus(mkI(6'h04, 1, 2, 8), 32'd7, 32'd7);
        checkOne("beq.taken", 32'(branch_taken), 32'd1);
        checkOutput("beq");
        applyStimulus(mkI(6'h05, 1, 2, 8), 32'd7, 32'd7);
        checkOne("bne.taken", 32'(branch_taken), 32'd0);
        checkOutput("bne");

        // Reset asserted mid-store, then released
        applyStimulus(mkI(6'h2B, 0, 0, 0), 32'h20, 32'h1234_5678);
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOne("midrst.clear", mem_read_data, 32'h0);
        tickClock();
        checkOne("midrst.blocked", mem_read_data, 32'h0);
        checkOutput("midrst");
        rst_n = 1'b1;
        #1;
        checkOne("midrst.release", mem_read_data, 32'h0);
        tickClock();
        checkOne("midrst.store", mem_read_data, 32'h1234_5678);
        checkOutput("postrst");

        // Illegal opcode: no controls, memory unchanged across an edge
        applyStimulus(mkI(6'h2B, 0, 0, 16'h40), 32'h0, 32'hCAFE_F00D);
        tickClock();
        applyStimulus(mkI(6'h3F, 1, 2, 0), 32'h40, 32'h0);
        checkOne("illegal.ctrl", {28'h0, regwrite, memwrite, memread, imm_reg}, 32'h0);
        checkOne("illegal.alu_op", 32'(alu_op), 32'd0);
        tickClock();
        checkOne("illegal.mem", mem_read_data, 32'hCAFE_F00D);
        checkOutput("illegal");

        // Random instruction stream against the reference model
        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            ins[31:26] = op_pool[$urandom_range(0, 13)];
            if (ins[31:26] == 6'h00) ins[5:0] = fn_pool[$urandom_range(0, 9)];
            a = $urandom;
            if (ins[31:26] == 6'h23 || ins[31:26] == 6'h2B) begin
                a = $urandom_range(0, 255);
                ins[15:0] = 16'($urandom_range(0, 255));
            end
            applyStimulus(ins, a, $urandom);
            checkOutput($sformatf("rand%0d", n));
            tickClock();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_alu_mem.md
Name: decode_alu_mem

Overview:
- Single-cycle execute slice of the MIPS-style core: instruction decode, ALU and data memory in one block.
- Sits between fetch/program_counter and reg_file.
- Takes the fetched instruction plus register-file read data. Produces decoded fields, control signals, ALU result, branch/jump flags and write-back data.
- Only state: the data-memory array, written on the clock edge.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words in data memory (power of two).
- MEM_AW, 6, word-address width, equal to log2(MEM_DEPTH).

Ports:
- clk, input, 1: clock; memory writes occur on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- instruction, input, 32: current instruction.
- rs_data, input, 32: register value addressed by rs.
- rt_data, input, 32: register value addressed by rt.
- opcode, output, 6: instruction[31:26].
- adr, output, 26: instruction[25:0].
- rs, output, 5: instruction[25:21].
- rt, output, 5: instruction[20:16].
- rd, output, 5: instruction[15:11].
- shamt, output, 5: instruction[10:6].
- funct, output, 6: instruction[5:0].
- imm, output, 16: instruction[15:0].
- dest_reg, output, 5: write-back register; rt when imm_reg=1, else rd.
- regwrite, output, 1: register write enable.
- memwrite, output, 1: memory write enable.
- memread, output, 1: load select.
- alu_op, output, 4: ALU operation code.
- imm_reg, output, 1: ALU B operand is the extended immediate.
- alu_result, output, 32: ALU result (also the memory address).
- zero, output, 1: alu_result == 0.
- branch_taken, output, 1: (beq & zero) | (bne & ~zero).
- jump, output, 1: opcode is j.
- mem_read_data, output, 32: memory word at the addressed location.
- write_data, output, 32: memread ? mem_read_data : alu_result.

Behaviour:
- Decode, ALU, muxes and memory read are purely combinational, zero latency.
- Field outputs are straight bit slices, independent of opcode.
- alu_op encoding (shared constants): ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLL=7, SRL=8.
- R-type (opcode 0x00), funct mapping:
  - 0x20→ADD, 0x22→SUB, 0x24→AND, 0x25→OR, 0x26→XOR, 0x27→NOR, 0x2A→SLT, 0x00→SLL, 0x02→SRL.
  - regwrite=1, imm_reg=0. shamt is ignored except for shifts.
  - Unknown funct: regwrite=0, alu_op=ADD.
- I-type mapping (all imm_reg=1 unless stated):
  - addi 0x08: ADD, sign-extended imm, regwrite=1.
  - slti 0x0A: SLT, sign-extended imm, regwrite=1.
  - andi 0x0C: AND, zero-extended imm, regwrite=1.
  - ori 0x0D: OR, zero-extended imm, regwrite=1.
  - lw 0x23: ADD, sign-extended imm, regwrite=1, memread=1.
  - sw 0x2B: ADD, sign-extended imm, memwrite=1, regwrite=0.
  - beq 0x04 / bne 0x05: SUB, imm_reg=0, no writes.
  - j 0x02: jump=1, no writes.
  - Any other opcode: all controls 0, alu_op=ADD.
- ALU operands:
  - A = rs_data. B = imm_reg ? extended imm : rt_data.
  - For SLL/SRL: A = rt_data, shift amount = shamt.
- ALU arithmetic:
  - 32-bit wrap-around, no overflow flag.
  - SLT is signed compare, result 1 or 0.
  - SRL is logical.
- Memory addressing:
  - Word index = alu_result[MEM_AW+1:2].
  - alu_result[1:0] is ignored; upper bits are ignored (address wraps).
- Memory write:
  - On rising clk with memwrite=1 and rst_n=1, mem[index] ← rt_data.
  - The read is combinational, so a same-address read after the edge returns the new data.
- Reset:
  - rst_n=0 asynchronously clears every memory word to 0 and blocks writes.
  - During reset mem_read_data=0; the other outputs follow their inputs combinationally.
  - Releasing reset mid-operation resumes normal writes from the next edge.

Decomposition:
- Shared package holds the opcode constants, funct constants and the 4-bit alu_op enum.
- Natural sub-modules: alu (combinational, with zero flag) and data_memory (array plus async clear).
- Decode logic stays in the top of this block.

Test Plan:
- Decode R-type: instruction=0x000A5B22 → opcode=0, rs=0, rt=10, rd=11, shamt=12, funct=0x22, imm=0x5B22, adr=0x00A5B22, alu_op=SUB(1), regwrite=1, memwrite=0, memread=0, imm_reg=0, dest_reg=11.
- ALU arithmetic: addi with rs_data=5, imm=0xFFFF → alu_result=4. sub 3−3 → zero=1. slt −1 vs 1 → 1. srl 0x80000000 by 31 → 1.
- Store then load: sw with rs_data=0x10, imm=4, rt_data=0xDEADBEEF, one clock; then lw at the same address → mem_read_data=write_data=0xDEADBEEF, memread=1, regwrite=1, dest_reg=rt.
- Branch: beq with rs_data=rt_data=7 → zero=1, branch_taken=1. bne with the same data → branch_taken=0.
- Reset mid-operation: store 0x12345678, assert rst_n=0 while memwrite=1 → memory reads 0 and no write happens. Release reset → the next store succeeds.
- Illegal opcode 0x3F: all controls 0, alu_op=ADD; a clock edge leaves memory unchanged.
